// File: rtl/fare_pkg.sv
// Shared types and constants for the fare account stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fare_pkg;

    // Control FSM: no card, card held with one debit allowed, debit consumed.
    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_HELD  = 2'b01,
        S_SPENT = 2'b10
    } fare_state_t;

    // Admin port opcodes.
    typedef enum logic [1:0] {
        OP_TOPUP      = 2'b00,
        OP_ACTIVATE   = 2'b01,
        OP_DEACTIVATE = 2'b10,
        OP_MONTHLY    = 2'b11
    } adm_op_t;

    // Fare debited per gate passage, in cents.
    localparam int DEFAULT_FARE = 300;

endpackage

// File: rtl/fare_account_table.sv
// Per-card account register array: active flag, monthly flag, balance.
// Latency: reads are combinational; writes commit on the clock edge.
// Backpressure: none; debit write wins over admin write (caller keeps them exclusive).
// Ports: three read addresses (tap, held card, admin target), debit write (balance
// only, at the held card) and admin write (whole entry, at the admin target).
module fare_account_table #(
    parameter int N_CARDS = 16,
    parameter int ID_W    = 4,
    parameter int BAL_W   = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    // tap lookup
    input  logic [ID_W-1:0]  tap_addr,
    output logic             tap_active,
    output logic             tap_mon,
    output logic [BAL_W-1:0] tap_bal,
    // held-card balance read and debit write
    input  logic [ID_W-1:0]  cur_addr,
    output logic [BAL_W-1:0] cur_bal,
    input  logic             dbt_en,
    input  logic [BAL_W-1:0] dbt_bal,
    // admin target read and write
    input  logic [ID_W-1:0]  adm_addr,
    output logic             adm_active,
    output logic             adm_mon,
    output logic [BAL_W-1:0] adm_bal,
    input  logic             adm_en,
    input  logic             adm_wactive,
    input  logic             adm_wmon,
    input  logic [BAL_W-1:0] adm_wbal
);

    logic             active_q [N_CARDS];
    logic             mon_q    [N_CARDS];
    logic [BAL_W-1:0] bal_q    [N_CARDS];

    assign tap_active = active_q[tap_addr];
    assign tap_mon    = mon_q[tap_addr];
    assign tap_bal    = bal_q[tap_addr];
    assign cur_bal    = bal_q[cur_addr];
    assign adm_active = active_q[adm_addr];
    assign adm_mon    = mon_q[adm_addr];
    assign adm_bal    = bal_q[adm_addr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CARDS; i++) begin
                active_q[i] <= 1'b0;
                mon_q[i]    <= 1'b0;
                bal_q[i]    <= '0;
            end
        end else if (dbt_en) begin
            bal_q[cur_addr] <= dbt_bal;
        end else if (adm_en) begin
            active_q[adm_addr] <= adm_wactive;
            mon_q[adm_addr]    <= adm_wmon;
            bal_q[adm_addr]    <= adm_wbal;
        end
    end

endmodule

// File: rtl/fare_account_unit.sv
// Card-account stage ahead of the gate FSM: tap lookup, single debit per tap, admin edits.
// Latency: qualifiers registered 1 cycle after tap; debit visible on balance next cycle.
// Backpressure: adm_ready drops only in a cycle where a debit is being processed.
// Ports: tap_valid/tap_id (NFC), reduce_bal (gate debit pulse), adm_* (station
// controller), card_active/monthly/fund_enough/balance/debit_err (to gate).
module fare_account_unit
    import fare_pkg::*;
#(
    parameter int N_CARDS = 16,
    parameter int ID_W    = 4,
    parameter int BAL_W   = 12,
    parameter int FARE    = DEFAULT_FARE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tap_valid,
    input  logic [ID_W-1:0]  tap_id,
    input  logic             reduce_bal,
    input  logic             adm_valid,
    input  logic [1:0]       adm_op,
    input  logic [ID_W-1:0]  adm_id,
    input  logic [BAL_W-1:0] adm_amount,
    output logic             adm_ready,
    output logic             card_active,
    output logic             monthly,
    output logic             fund_enough,
    output logic [BAL_W-1:0] balance,
    output logic             debit_err
);

    localparam logic [BAL_W:0] FARE_X = (BAL_W+1)'(FARE);

    function automatic logic covers_fare(input logic [BAL_W-1:0] bal);
        return {1'b0, bal} >= FARE_X;
    endfunction

    fare_state_t      state, state_nxt;
    logic [ID_W-1:0]  cur_id;

    logic             tap_act, tap_mon;
    logic [BAL_W-1:0] tap_bal, cur_bal;
    logic             adm_act_rd, adm_mon_rd;
    logic [BAL_W-1:0] adm_bal_rd;

    logic             debit_req, debit_ok, debit_fail, adm_fire, refresh;
    logic [BAL_W-1:0] debit_bal;
    logic [BAL_W:0]   topup_sum;
    logic             new_act, new_mon;
    logic [BAL_W-1:0] new_bal;

    // A debit is only considered when held and not pre-empted by a new tap.
    assign debit_req  = reduce_bal && (state == S_HELD) && !tap_valid;
    assign debit_ok   = debit_req && card_active && !monthly && covers_fare(cur_bal);
    assign debit_bal  = cur_bal - FARE_X[BAL_W-1:0];
    assign debit_fail = (debit_req && !debit_ok) ||
                        (reduce_bal && (state == S_IDLE) && !tap_valid);

    // Debit owns the table write port in its cycle, so admin is held off.
    assign adm_ready  = !debit_req;
    assign adm_fire   = adm_valid && adm_ready;
    // A tap replaces the held card, so it overrides any refresh of the old one.
    assign refresh    = adm_fire && (adm_id == cur_id) && (state != S_IDLE) && !tap_valid;

    // Admin entry update, including saturating top-up.
    always_comb begin
        new_act   = adm_act_rd;
        new_mon   = adm_mon_rd;
        new_bal   = adm_bal_rd;
        topup_sum = {1'b0, adm_bal_rd} + {1'b0, adm_amount};
        case (adm_op_t'(adm_op))
            OP_TOPUP:      new_bal = topup_sum[BAL_W] ? '1 : topup_sum[BAL_W-1:0];
            OP_ACTIVATE:   new_act = 1'b1;
            OP_DEACTIVATE: begin
                new_act = 1'b0;
                new_mon = 1'b0;
            end
            OP_MONTHLY: begin
                new_act = 1'b1;
                new_mon = 1'b1;
            end
            default: ;
        endcase
    end

    fare_account_table #(
        .N_CARDS (N_CARDS),
        .ID_W    (ID_W),
        .BAL_W   (BAL_W)
    ) u_table (
        .clk         (clk),
        .rst_n       (rst_n),
        .tap_addr    (tap_id),
        .tap_active  (tap_act),
        .tap_mon     (tap_mon),
        .tap_bal     (tap_bal),
        .cur_addr    (cur_id),
        .cur_bal     (cur_bal),
        .dbt_en      (debit_ok),
        .dbt_bal     (debit_bal),
        .adm_addr    (adm_id),
        .adm_active  (adm_act_rd),
        .adm_mon     (adm_mon_rd),
        .adm_bal     (adm_bal_rd),
        .adm_en      (adm_fire),
        .adm_wactive (new_act),
        .adm_wmon    (new_mon),
        .adm_wbal    (new_bal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (tap_valid)                               state_nxt = S_HELD;
        else if (reduce_bal && (state == S_HELD))    state_nxt = S_SPENT;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_id      <= '0;
            card_active <= 1'b0;
            monthly     <= 1'b0;
            fund_enough <= 1'b0;
            balance     <= '0;
            debit_err   <= 1'b0;
        end else begin
            debit_err <= debit_fail;
            if (tap_valid) begin
                // Lookup sees the table as it was before this edge.
                cur_id      <= tap_id;
                card_active <= tap_act;
                monthly     <= tap_mon && tap_act;
                fund_enough <= tap_act && covers_fare(tap_bal);
                balance     <= tap_bal;
            end else if (refresh) begin
                card_active <= new_act;
                monthly     <= new_mon && new_act;
                fund_enough <= new_act && covers_fare(new_bal);
                balance     <= new_bal;
            end else if (debit_ok) begin
                balance     <= debit_bal;
            end
        end
    end

endmodule

// File: tb/tb_fare_account_unit.sv
module tb_fare_account_unit;

    localparam int FARE    = 300;
    localparam int BAL_MAX = 4095;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        tap_valid = 1'b0;
    logic [3:0]  tap_id = '0;
    logic        reduce_bal = 1'b0;
    logic        adm_valid = 1'b0;
    logic [1:0]  adm_op = '0;
    logic [3:0]  adm_id = '0;
    logic [11:0] adm_amount = '0;
    logic        adm_ready;
    logic        card_active, monthly, fund_enough, debit_err;
    logic [11:0] balance;

    fare_account_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tap_valid   (tap_valid),
        .tap_id      (tap_id),
        .reduce_bal  (reduce_bal),
        .adm_valid   (adm_valid),
        .adm_op      (adm_op),
        .adm_id      (adm_id),
        .adm_amount  (adm_amount),
        .adm_ready   (adm_ready),
        .card_active (card_active),
        .monthly     (monthly),
        .fund_enough (fund_enough),
        .balance     (balance),
        .debit_err   (debit_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: account table and what the gate should see.
    bit m_act [16];
    bit m_mon [16];
    int m_bal [16];
    int held;
    int mode;          // 0 no card, 1 card held, 2 debit used
    bit e_ca, e_mo, e_fe, e_err, e_rdy;
    int e_bal;
    bit last_rdy;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_act[i] = 0;
            m_mon[i] = 0;
            m_bal[i] = 0;
        end
        held = 0; mode = 0;
        e_ca = 0; e_mo = 0; e_fe = 0; e_err = 0; e_bal = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".active"}, int'(card_active), int'(e_ca));
        chk({tag, ".monthly"}, int'(monthly), int'(e_mo));
        chk({tag, ".fund"}, int'(fund_enough), int'(e_fe));
        chk({tag, ".balance"}, int'(balance), e_bal);
        chk({tag, ".err"}, int'(debit_err), int'(e_err));
    endtask

    // One clock cycle: drive at the falling edge, predict, check after the next rise.
    task automatic cycle(input bit tv, input int tid, input bit rb,
                         input bit av, input int op, input int aid, input int amt);
        int pre_mode, pre_held;
        tap_valid  = tv;
        tap_id     = 4'(tid);
        reduce_bal = rb;
        adm_valid  = av;
        adm_op     = 2'(op);
        adm_id     = 4'(aid);
        adm_amount = 12'(amt);
        #1;
        pre_mode = mode;
        pre_held = held;
        e_rdy = !(rb && mode == 1 && !tv);
        last_rdy = adm_ready;
        chk("adm_ready", int'(adm_ready), int'(e_rdy));
        e_err = 0;
        if (tv) begin
            held = tid;
            e_ca = m_act[tid];
            e_mo = m_mon[tid] && m_act[tid];
            e_fe = m_act[tid] && (m_bal[tid] >= FARE);
            e_bal = m_bal[tid];
            mode = 1;
        end else if (rb) begin
            if (mode == 1) begin
                if (e_ca && !e_mo && m_bal[held] >= FARE) begin
                    m_bal[held] = m_bal[held] - FARE;
                    e_bal = m_bal[held];
                end else begin
                    e_err = 1;
                end
                mode = 2;
            end else if (mode == 0) begin
                e_err = 1;
            end
        end
        if (av && e_rdy) begin
            case (op)
                0: m_bal[aid] = (m_bal[aid] + amt > BAL_MAX) ? BAL_MAX : m_bal[aid] + amt;
                1: m_act[aid] = 1;
                2: begin m_act[aid] = 0; m_mon[aid] = 0; end
                default: begin m_act[aid] = 1; m_mon[aid] = 1; end
            endcase
            if (!tv && pre_mode != 0 && aid == pre_held) begin
                e_ca = m_act[aid];
                e_mo = m_mon[aid] && m_act[aid];
                e_fe = m_act[aid] && (m_bal[aid] >= FARE);
                e_bal = m_bal[aid];
            end
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs("cyc");
    endtask

    task automatic idle_inputs();
        tap_valid = 0; reduce_bal = 0; adm_valid = 0;
    endtask

    initial begin
        model_reset();
        #1 rst_n = 1'b0;
        #3;
        check_outputs("reset");
        chk("reset.ready", int'(adm_ready), 1);
        @(negedge clk);
        rst_n = 1'b1;

        // Unknown/inactive card: nothing qualifies, debit rejected.
        cycle(1, 3, 0, 0, 0, 0, 0);
        chk("tap3.active", int'(card_active), 0);
        chk("tap3.balance", int'(balance), 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        chk("tap3.err", int'(debit_err), 1);

        // Activate and fund card 5, then a single debit.
        cycle(0, 0, 0, 1, 1, 5, 0);
        cycle(0, 0, 0, 1, 0, 5, 1000);
        cycle(1, 5, 0, 0, 0, 0, 0);
        chk("c5.fund", int'(fund_enough), 1);
        chk("c5.bal1000", int'(balance), 1000);
        cycle(0, 0, 1, 0, 0, 0, 0);
        chk("c5.bal700", int'(balance), 700);
        cycle(0, 0, 1, 0, 0, 0, 0);
        chk("c5.spent.bal", int'(balance), 700);
        chk("c5.spent.err", int'(debit_err), 0);

        // Drain card 5 to 200 (100 after two debits, then top-up refresh).
        cycle(1, 5, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(1, 5, 0, 0, 0, 0, 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 5, 100);
        chk("c5.refresh", int'(balance), 200);
        cycle(1, 5, 0, 0, 0, 0, 0);
        chk("c5.low.fund", int'(fund_enough), 0);
        cycle(0, 0, 1, 0, 0, 0, 0);
        chk("c5.low.err", int'(debit_err), 1);
        chk("c5.low.bal", int'(balance), 200);

        // Monthly pass is never debited.
        cycle(0, 0, 0, 1, 3, 7, 0);
        cycle(1, 7, 0, 0, 0, 0, 0);
        chk("c7.monthly", int'(monthly), 1);
        chk("c7.active", int'(card_active), 1);
        cycle(0, 0, 1, 0, 0, 0, 0);
        chk("c7.bal", int'(balance), 0);

        // Saturating top-up, and admin held off during a debit cycle.
        cycle(0, 0, 0, 1, 1, 9, 0);
        cycle(0, 0, 0, 1, 0, 9, 300);
        cycle(0, 0, 0, 1, 0, 9, 4000);
        cycle(1, 9, 0, 0, 0, 0, 0);
        chk("c9.sat", int'(balance), 4095);
        cycle(0, 0, 1, 1, 0, 2, 50);
        chk("blk.ready", int'(last_rdy), 0);
        chk("c9.debit", int'(balance), 3795);
        cycle(0, 0, 0, 1, 0, 2, 50);
        chk("retry.ready", int'(last_rdy), 1);
        cycle(1, 2, 0, 0, 0, 0, 0);
        chk("c2.bal", int'(balance), 50);

        // Asynchronous reset while a card is held.
        cycle(1, 5, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        #1;
        chk("arst.active", int'(card_active), 0);
        chk("arst.balance", int'(balance), 0);
        chk("arst.fund", int'(fund_enough), 0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 5, 0, 0, 0, 0, 0);
        chk("arst.tap5", int'(card_active), 0);

        // Randomized traffic over a few hot IDs plus occasional others.
        for (int n = 0; n < 600; n++) begin
            bit tv, rb, av;
            int tid, aid, op, amt;
            tv  = ($urandom_range(0, 3) == 0);
            rb  = ($urandom_range(0, 4) < 2);
            av  = ($urandom_range(0, 4) < 2);
            tid = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            aid = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            op  = $urandom_range(0, 3);
            if (op == 2 && $urandom_range(0, 2) != 0) op = 0;
            amt = ($urandom_range(0, 7) == 0) ? $urandom_range(3000, 4095) : $urandom_range(0, 600);
            cycle(tv, tid, rb, av, op, aid, amt);
        end

        idle_inputs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
